// File: rtl/valid_rx_checker_if.sv
// Strobe-stream bundle between a periodic valid source and the rx checker.
// The master drives in_* and observes out_*; the checker (slave) does the reverse.
interface valid_rx_checker_if #(
  parameter int DW = 16
);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic [DW-1:0] out_data;

  modport master (output in_valid, in_data, input out_valid, out_data);
  modport slave  (input in_valid, in_data, output out_valid, out_data);
endinterface

// File: rtl/valid_rx_checker.sv
// Sink/monitor for a periodic valid strobe: registers accepted samples (1-cycle latency),
// checks the strobe period, flags early/late strobes and tracks lock. No backpressure: never stalls.
module valid_rx_checker #(
  parameter int CYCLES = 5,
  parameter int DW     = 16,
  parameter int LOCK_N = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  valid_rx_checker_if.slave  bus,
  output logic [31:0]        samp_cnt,
  output logic               err_early,
  output logic               err_late,
  output logic [15:0]        err_cnt,
  output logic               locked
);
  localparam int CW = $clog2(CYCLES + 1);
  localparam int GW = $clog2(LOCK_N + 1);
  localparam logic [CW-1:0] DUE    = CW'(CYCLES - 1);
  localparam logic [CW-1:0] SAT    = CW'(CYCLES);
  localparam logic [GW-1:0] GOOD_N = GW'(LOCK_N);

  typedef enum logic [1:0] {IDLE, ACQ, LOCK} state_t;

  state_t        state, state_n;
  logic [CW-1:0] int_cnt;
  logic [GW-1:0] good_cnt, good_cnt_n;
  logic [DW-1:0] data_q;
  logic          accept, checking, good, early, late, reanchor;

  assign bus.out_data = data_q;

  always_comb begin
    accept   = en & bus.in_valid;
    checking = en & (state != IDLE);
    good     = checking & accept & (int_cnt == DUE);
    early    = checking & accept & (int_cnt < DUE);
    reanchor = checking & accept & (int_cnt == SAT);
    // With a 1-cycle period every enabled cycle is a due cycle, so saturation cannot mute late.
    late     = checking & ~accept & ((int_cnt == DUE) | (CYCLES == 1));
  end

  always_comb begin
    state_n    = state;
    good_cnt_n = good_cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n    = ACQ;
          good_cnt_n = '0;
        end
      end
      ACQ: begin
        if (good) begin
          good_cnt_n = good_cnt + GW'(1);
          if (good_cnt_n == GOOD_N) state_n = LOCK;
        end else if (early | late | reanchor) begin
          good_cnt_n = '0;
        end
      end
      LOCK: begin
        if (early | late) begin
          state_n    = ACQ;
          good_cnt_n = '0;
        end
      end
      default: begin
        state_n    = IDLE;
        good_cnt_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      good_cnt      <= '0;
      int_cnt       <= '0;
      locked        <= 1'b0;
      bus.out_valid <= 1'b0;
      data_q        <= '0;
      samp_cnt      <= '0;
      err_early     <= 1'b0;
      err_late      <= 1'b0;
      err_cnt       <= '0;
    end else if (clr) begin
      state         <= IDLE;
      good_cnt      <= '0;
      int_cnt       <= '0;
      locked        <= 1'b0;
      bus.out_valid <= 1'b0;
      data_q        <= '0;
      samp_cnt      <= '0;
      err_early     <= 1'b0;
      err_late      <= 1'b0;
      err_cnt       <= '0;
    end else begin
      state         <= state_n;
      good_cnt      <= good_cnt_n;
      locked        <= (state_n == LOCK);
      bus.out_valid <= accept;
      err_early     <= early;
      err_late      <= late;
      if (accept) begin
        data_q   <= bus.in_data;
        samp_cnt <= samp_cnt + 32'd1;
        int_cnt  <= '0;
      end else if (en && int_cnt != SAT) begin
        int_cnt  <= int_cnt + CW'(1);
      end
      if ((early | late) && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_valid_rx_checker.sv
// Randomised bench for valid_rx_checker against an interval-based reference model.
// Model tracks absolute enabled-cycle indices of accepts rather than a saturating counter.
module tb_valid_rx_checker;
  localparam int CYC   = 5;
  localparam int LOCKN = 3;

  logic        clk, rst, en, clr;
  logic [31:0] samp_cnt;
  logic        err_early, err_late, locked;
  logic [15:0] err_cnt;

  valid_rx_checker_if #(.DW(16)) bus ();

  valid_rx_checker #(.CYCLES(CYC), .DW(16), .LOCK_N(LOCKN)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .bus(bus),
    .samp_cnt(samp_cnt), .err_early(err_early), .err_late(err_late),
    .err_cnt(err_cnt), .locked(locked)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: mode 0=idle, 1=acquiring, 2=locked
  logic        m_ov, m_early, m_late;
  logic [15:0] m_od, m_errcnt;
  logic [31:0] m_samp;
  int          m_mode, m_good, m_idx, m_last;

  function automatic logic [67:0] dut_vec();
    return {bus.out_valid, bus.out_data, samp_cnt, err_early, err_late, err_cnt, locked};
  endfunction

  function automatic logic [67:0] mdl_vec();
    return {m_ov, m_od, m_samp, m_early, m_late, m_errcnt, (m_mode == 2)};
  endfunction

  task automatic mdl_reset();
    m_ov = 0; m_early = 0; m_late = 0; m_od = 0; m_errcnt = 0; m_samp = 0;
    m_mode = 0; m_good = 0; m_last = m_idx;
  endtask

  task automatic model(input logic e, input logic v, input logic [15:0] d, input logic c);
    int gap;
    if (c) begin
      mdl_reset();
      return;
    end
    m_early = 0;
    m_late  = 0;
    if (!e) begin
      m_ov = 0;
      return;
    end
    m_idx++;
    gap  = m_idx - m_last;
    m_ov = v;
    if (v) begin
      m_od = d;
      m_samp++;
      if (m_mode == 0) begin
        m_mode = 1; m_good = 0;
      end else if (gap == CYC) begin
        m_good++;
        if (m_mode == 1 && m_good == LOCKN) m_mode = 2;
      end else if (gap < CYC) begin
        m_early = 1; m_mode = 1; m_good = 0;
      end else begin
        m_good = 0;
      end
      m_last = m_idx;
    end else if (m_mode != 0 && gap == CYC) begin
      m_late = 1; m_mode = 1; m_good = 0;
    end
    if ((m_early || m_late) && m_errcnt != 16'hFFFF) m_errcnt++;
  endtask

  // Called at a falling edge; drives inputs, advances one clock, returns at the next falling edge.
  task automatic step(input logic e, input logic v, input logic [15:0] d, input logic c);
    en = e; bus.in_valid = v; bus.in_data = d; clr = c;
    @(posedge clk);
    model(e, v, d, c);
    @(negedge clk);
  endtask

  task automatic test_reset();
    tests++;
    if (dut_vec() !== 68'd0) begin
      fails++; $display("FAIL reset_state: got=%h want=0", dut_vec());
    end
    step(1, 0, 16'h0, 0);
    tests++;
    if (dut_vec() !== mdl_vec() || err_late !== 1'b0) begin
      fails++; $display("FAIL idle_no_late: got=%h want=%h", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_lock();
    logic [15:0] s;
    s = 0;
    step(1, 0, 16'h0, 1);
    for (int i = 0; i < 46; i++) begin
      if (i % 5 == 0) begin
        s++;
        step(1, 1, s, 0);
      end else begin
        step(1, 0, 16'($urandom), 0);
      end
      tests++;
      if (dut_vec() !== mdl_vec()) begin
        fails++; $display("FAIL lock_cyc%0d: got=%h want=%h", i, dut_vec(), mdl_vec());
      end
      if (i == 10) begin
        tests++;
        if (locked !== 1'b0) begin fails++; $display("FAIL lock_early3: got=%b want=0", locked); end
      end
      if (i == 15) begin
        tests++;
        if (locked !== 1'b1) begin fails++; $display("FAIL lock_after4: got=%b want=1", locked); end
      end
    end
    tests++;
    if (samp_cnt !== 32'd10 || err_cnt !== 16'd0 || bus.out_data !== 16'd10 || bus.out_valid !== 1'b1) begin
      fails++;
      $display("FAIL lock_totals: samp=%0d err=%0d data=%0d ov=%b want 10/0/10/1",
               samp_cnt, err_cnt, bus.out_data, bus.out_valid);
    end
  endtask

  task automatic test_early();
    int gaps[4] = '{3, 5, 5, 5};
    foreach (gaps[g]) begin
      for (int i = 1; i <= gaps[g]; i++) begin
        step(1, i == gaps[g], 16'($urandom), 0);
        tests++;
        if (dut_vec() !== mdl_vec()) begin
          fails++; $display("FAIL early_g%0d_c%0d: got=%h want=%h", g, i, dut_vec(), mdl_vec());
        end
      end
      if (g == 0) begin
        tests++;
        if (err_early !== 1'b1 || err_cnt !== 16'd1 || locked !== 1'b0) begin
          fails++; $display("FAIL early_pulse: early=%b cnt=%0d lock=%b want 1/1/0", err_early, err_cnt, locked);
        end
      end
    end
    tests++;
    if (locked !== 1'b1) begin fails++; $display("FAIL early_relock: got=%b want=1", locked); end
  endtask

  task automatic test_late();
    int gaps[4] = '{10, 5, 5, 5};
    int lates;
    logic [15:0] base;
    lates = 0;
    base  = m_errcnt;
    foreach (gaps[g]) begin
      for (int i = 1; i <= gaps[g]; i++) begin
        step(1, i == gaps[g], 16'($urandom), 0);
        lates += int'(err_late);
        tests++;
        if (dut_vec() !== mdl_vec()) begin
          fails++; $display("FAIL late_g%0d_c%0d: got=%h want=%h", g, i, dut_vec(), mdl_vec());
        end
        if (g == 0 && i == 5) begin
          tests++;
          if (err_late !== 1'b1 || locked !== 1'b0) begin
            fails++; $display("FAIL late_due: late=%b lock=%b want 1/0", err_late, locked);
          end
        end
      end
    end
    tests++;
    if (lates != 1 || err_cnt !== base + 16'd1 || locked !== 1'b1) begin
      fails++;
      $display("FAIL late_summary: pulses=%0d cnt=%0d lock=%b want 1/%0d/1", lates, err_cnt, locked, base + 16'd1);
    end
  endtask

  task automatic test_enable_gap();
    logic [15:0] base;
    base = m_errcnt;
    for (int p = 0; p < 3; p++) begin
      for (int i = 1; i <= CYC; i++) begin
        if (p == 0 && i == 3) begin
          for (int k = 0; k < 7; k++) begin
            step(0, 1'($urandom), 16'($urandom), 0);
            tests++;
            if (dut_vec() !== mdl_vec() || locked !== 1'b1) begin
              fails++; $display("FAIL engap_off%0d: got=%h want=%h", k, dut_vec(), mdl_vec());
            end
          end
        end
        step(1, i == CYC, 16'($urandom), 0);
        tests++;
        if (dut_vec() !== mdl_vec() || locked !== 1'b1) begin
          fails++; $display("FAIL engap_p%0d_c%0d: got=%h want=%h", p, i, dut_vec(), mdl_vec());
        end
      end
    end
    tests++;
    if (err_cnt !== base) begin fails++; $display("FAIL engap_errs: got=%0d want=%0d", err_cnt, base); end
  endtask

  task automatic test_clr_async();
    step(1, 0, 16'h0, 0);
    step(1, 0, 16'h0, 0);
    #2 rst = 1;
    #1;
    tests++;
    if (dut_vec() !== 68'd0) begin fails++; $display("FAIL async_rst: got=%h want=0", dut_vec()); end
    @(negedge clk);
    rst = 0;
    mdl_reset();
    for (int i = 1; i <= 2; i++) begin
      step(1, i == 2, 16'hA5A5, 0);
      tests++;
      if (dut_vec() !== mdl_vec() || err_early !== 1'b0) begin
        fails++; $display("FAIL rst_first_unchecked%0d: got=%h want=%h", i, dut_vec(), mdl_vec());
      end
    end
    step(1, 1, 16'h1234, 1);
    tests++;
    if (dut_vec() !== 68'd0) begin fails++; $display("FAIL clr_with_accept: got=%h want=0", dut_vec()); end
    step(1, 1, 16'h5678, 0);
    tests++;
    if (dut_vec() !== mdl_vec() || err_early !== 1'b0 || samp_cnt !== 32'd1) begin
      fails++; $display("FAIL clr_first_unchecked: got=%h want=%h", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_random();
    int k;
    logic e, v;
    k = 0;
    for (int i = 0; i < 600; i++) begin
      e = ($urandom % 6) != 0;
      if (e) k++;
      v = (k % CYC == 0) ? (($urandom % 10) != 0) : (($urandom % 20) == 0);
      step(e, v, 16'($urandom), ($urandom % 250) == 0);
      tests++;
      if (dut_vec() !== mdl_vec()) begin
        fails++; $display("FAIL random_c%0d: got=%h want=%h", i, dut_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_saturate();
    step(1, 0, 16'h0, 1);
    for (int i = 0; i < 65540; i++) begin
      step(1, 1, 16'(i), 0);
      tests++;
      if (dut_vec() !== mdl_vec()) begin
        fails++; $display("FAIL sat_c%0d: got=%h want=%h", i, dut_vec(), mdl_vec());
      end
    end
    tests++;
    if (err_cnt !== 16'hFFFF || samp_cnt !== 32'd65540) begin
      fails++; $display("FAIL sat_hold: err=%h samp=%0d want FFFF/65540", err_cnt, samp_cnt);
    end
  endtask

  initial begin
    clk = 0; rst = 1; en = 0; clr = 0;
    bus.in_valid = 0; bus.in_data = 0;
    m_idx = 0;
    mdl_reset();
    repeat (2) @(negedge clk);
    rst = 0;
    test_reset();
    test_lock();
    test_early();
    test_late();
    test_enable_gap();
    test_clr_async();
    test_random();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
